// File: rtl/axis_bfm_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
// Covers FSM and pattern encodings, LFSR step and last-beat keep mask.
package axis_bfm_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_t;
    typedef enum logic [1:0] {INCR = 2'd0, LFSR = 2'd1, CONST = 2'd2} gen_mode_t;

    // x^32 + x^22 + x^2 + x + 1, feedback taps at bits 22, 2, 1, 0
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'd0);
    endfunction

    function automatic logic [63:0] keep_mask(input int unsigned bytes, input int unsigned data_w);
        int unsigned bpb;
        int unsigned rem;
        bpb = data_w / 8;
        rem = bytes % bpb;
        if (rem == 0)
            keep_mask = (bpb >= 64) ? '1 : ((64'd1 << bpb) - 64'd1);
        else
            keep_mask = (64'd1 << rem) - 64'd1;
    endfunction

    function automatic logic [31:0] pat_sel(input gen_mode_t mode, input logic [31:0] seed,
                                            input logic [31:0] incr, input logic [31:0] lfsr);
        case (mode)
            INCR:    pat_sel = incr;
            LFSR:    pat_sel = lfsr;
            default: pat_sel = seed;
        endcase
    endfunction

endpackage

// File: rtl/axis_master_gen_if.sv
// AXI-Stream bus bundle used between the generator and its sink.
interface axis_master_gen_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;
    logic                  tuser;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and per-beat advance.
module axis_lfsr32
    import axis_bfm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_advance,
    output logic [31:0] o_value
);
    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= 32'd1;
        else if (i_load)
            r_state <= i_load_val;
        else if (i_advance)
            r_state <= lfsr_step(r_state);
    end

    assign o_value = r_state;
endmodule

// File: rtl/axis_master_gen.sv
// AXI-Stream packet generator: programmable length, count, gap and data pattern.
// All m_* outputs come straight from registers and hold while stalled.
module axis_master_gen
    import axis_bfm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_bytes,
    input  logic [CNT_W-1:0]  cfg_pkts,
    input  logic [CNT_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_mode,
    input  logic [31:0]       cfg_seed,
    input  logic [DEST_W-1:0] cfg_dest,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_sent,
    axis_master_gen_if.master m
);
    localparam int unsigned BPB  = DATA_W / 8;
    localparam int unsigned REPS = (DATA_W + 31) / 32;

    gen_state_t         r_state, w_state_nxt;
    gen_mode_t          r_mode, w_mode_cfg;
    logic [LEN_W-1:0]   r_beats, r_beat, w_eff_bytes, w_beats_cfg;
    logic [CNT_W-1:0]   r_pkts, r_gap, r_gap_cnt, r_pkt_sent, w_pkt_next;
    logic [31:0]        r_seed, r_incr, w_lfsr_val, w_lfsr_first, w_p_first, w_p_next;
    logic [BPB-1:0]     r_last_keep, w_last_keep_cfg, r_tkeep;
    logic [DATA_W-1:0]  r_tdata, w_d_first, w_d_next;
    logic [REPS*32-1:0] w_rep_first, w_rep_next;
    logic [ID_W-1:0]    r_tid;
    logic [DEST_W-1:0]  r_tdest;
    logic               r_tvalid, r_tlast, r_tuser, r_busy, r_done;
    logic               w_fire, w_last_beat, w_next_is_last, w_final_pkt;
    logic               w_latch, w_beat_adv, w_pkt_begin, w_go_gap, w_finish;

    assign w_mode_cfg      = (cfg_mode == 2'd3) ? CONST : gen_mode_t'(cfg_mode);
    assign w_eff_bytes     = (cfg_bytes == '0) ? LEN_W'(1) : cfg_bytes;
    assign w_beats_cfg     = LEN_W'(({1'b0, w_eff_bytes} + (LEN_W+1)'(BPB - 1)) / (LEN_W+1)'(BPB));
    assign w_last_keep_cfg = BPB'(keep_mask(32'(w_eff_bytes), DATA_W));

    assign w_fire         = r_tvalid & m.tready;
    assign w_last_beat    = (r_beat == r_beats - LEN_W'(1));
    assign w_next_is_last = (r_beat + LEN_W'(2) == r_beats);
    assign w_pkt_next     = r_pkt_sent + CNT_W'(1);
    assign w_final_pkt    = (w_pkt_next == r_pkts);

    // The pattern for the upcoming beat: counters/LFSR have already moved on if
    // no beat retires this cycle (GAP exit), otherwise step them once more.
    assign w_lfsr_first = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
    assign w_p_first    = pat_sel(w_mode_cfg, cfg_seed, cfg_seed, w_lfsr_first);
    assign w_p_next     = pat_sel(r_mode, r_seed,
                                  w_fire ? r_incr + 32'd1 : r_incr,
                                  w_fire ? lfsr_step(w_lfsr_val) : w_lfsr_val);
    assign w_rep_first  = {REPS{w_p_first}};
    assign w_rep_next   = {REPS{w_p_next}};
    assign w_d_first    = w_rep_first[DATA_W-1:0];
    assign w_d_next     = w_rep_next[DATA_W-1:0];

    axis_lfsr32 u_lfsr (
        .clk        (aclk),
        .rst        (areset),
        .i_load     (w_latch),
        .i_load_val (w_lfsr_first),
        .i_advance  (w_fire),
        .o_value    (w_lfsr_val)
    );

    always_ff @(posedge aclk) begin
        if (areset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_beat_adv  = 1'b0;
        w_pkt_begin = 1'b0;
        w_go_gap    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_latch     = 1'b1;
                w_state_nxt = (cfg_pkts == '0) ? DONE : SEND;
            end
            SEND: if (w_fire) begin
                if (!w_last_beat) begin
                    w_beat_adv = 1'b1;
                end else if (w_final_pkt) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_gap == '0) begin
                    w_pkt_begin = 1'b1;
                end else begin
                    w_go_gap    = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            GAP: if (r_gap_cnt == CNT_W'(1)) begin
                w_pkt_begin = 1'b1;
                w_state_nxt = SEND;
            end
            // DONE is left only once the done pulse has been shown, so an
            // empty run spends one extra cycle here before pulsing.
            DONE: if (r_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_beats <= '0;  r_beat <= '0;  r_pkts <= '0;  r_gap <= '0;  r_gap_cnt <= '0;
            r_pkt_sent <= '0;  r_mode <= INCR;  r_seed <= '0;  r_incr <= '0;  r_last_keep <= '0;
            r_tvalid <= 1'b0;  r_tlast <= 1'b0;  r_tuser <= 1'b0;  r_tdata <= '0;
            r_tkeep <= '0;  r_tid <= '0;  r_tdest <= '0;  r_busy <= 1'b0;  r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == SEND) || (w_state_nxt == GAP);
            r_done <= w_finish || (r_state == DONE && !r_done);
            if (w_fire) r_incr <= r_incr + 32'd1;
            if (r_state == GAP) r_gap_cnt <= r_gap_cnt - CNT_W'(1);

            if (w_latch) begin
                r_beats     <= w_beats_cfg;
                r_last_keep <= w_last_keep_cfg;
                r_pkts      <= cfg_pkts;
                r_gap       <= cfg_gap;
                r_mode      <= w_mode_cfg;
                r_seed      <= cfg_seed;
                r_incr      <= cfg_seed;
                r_pkt_sent  <= '0;
                r_beat      <= '0;
                r_tdest     <= cfg_dest;
                if (cfg_pkts != '0) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= w_d_first;
                    r_tuser  <= 1'b1;
                    r_tlast  <= (w_beats_cfg == LEN_W'(1));
                    r_tkeep  <= (w_beats_cfg == LEN_W'(1)) ? w_last_keep_cfg : '1;
                    r_tid    <= '0;
                end
            end

            if (w_fire && w_last_beat) r_pkt_sent <= w_pkt_next;

            if (w_beat_adv) begin
                r_beat  <= r_beat + LEN_W'(1);
                r_tdata <= w_d_next;
                r_tuser <= 1'b0;
                r_tlast <= w_next_is_last;
                r_tkeep <= w_next_is_last ? r_last_keep : '1;
            end

            if (w_pkt_begin) begin
                r_beat   <= '0;
                r_tvalid <= 1'b1;
                r_tdata  <= w_d_next;
                r_tuser  <= 1'b1;
                r_tlast  <= (r_beats == LEN_W'(1));
                r_tkeep  <= (r_beats == LEN_W'(1)) ? r_last_keep : '1;
                r_tid    <= ID_W'((r_state == GAP) ? r_pkt_sent : w_pkt_next);
            end

            if (w_go_gap || w_finish) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_tuser  <= 1'b0;
            end
            if (w_go_gap) r_gap_cnt <= r_gap;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign pkt_sent = r_pkt_sent;
    assign m.tvalid = r_tvalid;
    assign m.tdata  = r_tdata;
    assign m.tkeep  = r_tkeep;
    assign m.tstrb  = r_tkeep;
    assign m.tlast  = r_tlast;
    assign m.tuser  = r_tuser;
    assign m.tid    = r_tid;
    assign m.tdest  = r_tdest;
endmodule

// File: tb/tb_axis_master_gen.sv
// Directed bench for axis_master_gen: a 32-bit instance for all scenarios and a
// 64-bit instance for pattern replication.
module tb_axis_master_gen;
    logic        aclk = 1'b0;
    logic        areset, start, start64;
    logic [15:0] cfg_bytes, cfg_pkts, cfg_gap;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_seed;
    logic [3:0]  cfg_dest;
    logic        busy, done, busy64, done64;
    logic [15:0] pkt_sent, pkt_sent64;
    int          total = 0;
    int          bad = 0;

    axis_master_gen_if #(.DATA_W(32), .ID_W(4), .DEST_W(4)) m32 ();
    axis_master_gen_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) m64 ();

    axis_master_gen #(.DATA_W(32), .ID_W(4), .DEST_W(4), .LEN_W(16), .CNT_W(16)) u_dut (
        .aclk(aclk), .areset(areset), .start(start), .cfg_bytes(cfg_bytes), .cfg_pkts(cfg_pkts),
        .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_dest(cfg_dest),
        .busy(busy), .done(done), .pkt_sent(pkt_sent), .m(m32)
    );

    axis_master_gen #(.DATA_W(64), .ID_W(4), .DEST_W(4), .LEN_W(16), .CNT_W(16)) u_dut64 (
        .aclk(aclk), .areset(areset), .start(start64), .cfg_bytes(cfg_bytes), .cfg_pkts(cfg_pkts),
        .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_dest(cfg_dest),
        .busy(busy64), .done(done64), .pkt_sent(pkt_sent64), .m(m64)
    );

    always #5 aclk = ~aclk;

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic lst,
                            input logic usr, input logic [3:0] kp, input logic [3:0] id);
        chk({tag, ".valid"}, m32.tvalid, 1);
        chk({tag, ".data"},  m32.tdata, d);
        chk({tag, ".last"},  m32.tlast, lst);
        chk({tag, ".user"},  m32.tuser, usr);
        chk({tag, ".keep"},  m32.tkeep, kp);
        chk({tag, ".strb"},  m32.tstrb, kp);
        chk({tag, ".id"},    m32.tid, id);
    endtask

    logic [31:0] lf_exp [4] = '{32'h8000_0000, 32'h0040_0007, 32'h0080_000E, 32'h0100_001C};

    initial begin
        int j;
        int k;
        logic fire;
        areset = 1'b1; start = 1'b0; start64 = 1'b0;
        cfg_bytes = 16'd10; cfg_pkts = 16'd2; cfg_gap = 16'd0; cfg_mode = 2'd0;
        cfg_seed = 32'h100; cfg_dest = 4'd5;
        m32.tready = 1'b1; m64.tready = 1'b1;
        repeat (3) cyc();

        // reset state
        chk("rst.valid", m32.tvalid, 0);   chk("rst.last", m32.tlast, 0);
        chk("rst.user", m32.tuser, 0);     chk("rst.data", m32.tdata, 0);
        chk("rst.keep", m32.tkeep, 0);     chk("rst.id", m32.tid, 0);
        chk("rst.dest", m32.tdest, 0);     chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);          chk("rst.sent", pkt_sent, 0);
        chk("rst.valid64", m64.tvalid, 0); chk("rst.data64", m64.tdata, 0);
        areset = 1'b0;
        cyc();

        // 2 x 10-byte INCR packets, back to back
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1.busy", busy, 1);
        for (int b = 0; b < 6; b++) begin
            chk_beat($sformatf("t1b%0d", b), 32'h100 + 32'(b), (b % 3) == 2, (b % 3) == 0,
                     ((b % 3) == 2) ? 4'h3 : 4'hF, 4'(b / 3));
            chk($sformatf("t1b%0d.dest", b), m32.tdest, 5);
            cyc();
        end
        chk("t1.done", done, 1);  chk("t1.busy_end", busy, 0);
        chk("t1.valid_end", m32.tvalid, 0);  chk("t1.sent", pkt_sent, 2);
        cyc();
        chk("t1.done_pulse", done, 0);

        // same run with random backpressure
        start = 1'b1; cyc(); start = 1'b0;
        j = 0; k = 0;
        while (j < 6 && k < 200) begin
            m32.tready = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            chk_beat($sformatf("t2b%0d", j), 32'h100 + 32'(j), (j % 3) == 2, (j % 3) == 0,
                     ((j % 3) == 2) ? 4'h3 : 4'hF, 4'(j / 3));
            fire = m32.tready;
            cyc();
            k++;
            if (fire) j++;
        end
        chk("t2.beats", 64'(j), 6);
        chk("t2.done", done, 1);
        m32.tready = 1'b1;
        cyc();

        // single-beat CONST packets with 2-cycle gaps; cfg change after start ignored
        cfg_bytes = 16'd4; cfg_pkts = 16'd3; cfg_gap = 16'd2; cfg_mode = 2'd2;
        cfg_seed = 32'hDEAD_BEEF;
        start = 1'b1; cyc(); start = 1'b0;
        cfg_seed = 32'h0; cfg_gap = 16'd0;
        for (int c = 0; c < 7; c++) begin
            if (c % 3 == 0) begin
                chk_beat($sformatf("t3c%0d", c), 32'hDEAD_BEEF, 1, 1, 4'hF, 4'(c / 3));
            end else begin
                chk($sformatf("t3c%0d.gapvalid", c), m32.tvalid, 0);
                chk($sformatf("t3c%0d.busy", c), busy, 1);
            end
            cyc();
        end
        chk("t3.done", done, 1);  chk("t3.sent", pkt_sent, 3);
        cyc();

        // LFSR seed 0 -> starts from 1; 16 bytes -> 4 full beats
        cfg_bytes = 16'd16; cfg_pkts = 16'd1; cfg_gap = 16'd0; cfg_mode = 2'd1; cfg_seed = 32'h0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk_beat($sformatf("t4a%0d", b), 32'd1 << b, b == 3, b == 0, 4'hF, 4'h0);
            cyc();
        end
        chk("t4a.done", done, 1);
        cyc();

        // LFSR seed 0x80000000 on both widths at once
        cfg_seed = 32'h8000_0000;
        start = 1'b1; start64 = 1'b1; cyc(); start = 1'b0; start64 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk_beat($sformatf("t4b%0d", b), lf_exp[b], b == 3, b == 0, 4'hF, 4'h0);
            if (b < 2) begin
                chk($sformatf("t4w%0d.valid", b), m64.tvalid, 1);
                chk($sformatf("t4w%0d.data", b), m64.tdata, {lf_exp[b], lf_exp[b]});
                chk($sformatf("t4w%0d.last", b), m64.tlast, b == 1);
                chk($sformatf("t4w%0d.keep", b), m64.tkeep, 8'hFF);
            end
            if (b == 2) chk("t4w.done", done64, 1);
            cyc();
        end
        chk("t4b.done", done, 1);
        cyc();

        // empty run: done two cycles after start, never busy
        cfg_pkts = 16'd0; cfg_mode = 2'd0;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t5.valid1", m32.tvalid, 0);  chk("t5.busy1", busy, 0);  chk("t5.done1", done, 0);
        chk("t5.sent", pkt_sent, 0);
        cyc();
        chk("t5.done2", done, 1);  chk("t5.busy2", busy, 0);  chk("t5.valid2", m32.tvalid, 0);
        cyc();
        chk("t5.done3", done, 0);

        // start while busy is ignored
        cfg_bytes = 16'd4; cfg_pkts = 16'd2; cfg_gap = 16'd3; cfg_seed = 32'h10;
        start = 1'b1; cyc(); start = 1'b0;
        chk_beat("t5p0", 32'h10, 1, 1, 4'hF, 4'h0);
        cyc();
        chk("t5g1.valid", m32.tvalid, 0);
        start = 1'b1; cfg_pkts = 16'd0; cfg_seed = 32'h999;
        cyc();
        start = 1'b0;
        chk("t5g2.valid", m32.tvalid, 0);  chk("t5g2.busy", busy, 1);
        cyc();
        chk("t5g3.valid", m32.tvalid, 0);
        cyc();
        chk_beat("t5p1", 32'h11, 1, 1, 4'hF, 4'h1);
        cyc();
        chk("t5.done", done, 1);  chk("t5.sent2", pkt_sent, 2);
        cyc();

        // reset on beat 2 of a 5-beat packet, then a clean rerun
        cfg_bytes = 16'd20; cfg_pkts = 16'd1; cfg_gap = 16'd0; cfg_seed = 32'h200;
        start = 1'b1; cyc(); start = 1'b0;
        chk_beat("t6b0", 32'h200, 0, 1, 4'hF, 4'h0);
        cyc();
        chk_beat("t6b1", 32'h201, 0, 0, 4'hF, 4'h0);
        areset = 1'b1; cyc(); areset = 1'b0;
        chk("t6r.valid", m32.tvalid, 0);  chk("t6r.sent", pkt_sent, 0);
        chk("t6r.busy", busy, 0);         chk("t6r.data", m32.tdata, 0);
        chk("t6r.done", done, 0);
        start = 1'b1; cyc(); start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk_beat($sformatf("t6c%0d", b), 32'h200 + 32'(b), b == 4, b == 0, 4'hF, 4'h0);
            cyc();
        end
        chk("t6.done", done, 1);  chk("t6.sent", pkt_sent, 1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_master_gen.md
# axis_master_gen

Synthesizable, parametrised AXI-Stream packet generator replacing the single-beat master stimulus block. It emits a programmable number of packets with programmable byte length, inter-packet gap and data pattern, and holds AXI-Stream protocol at all times: tvalid never waits on tready, and payload stays stable until accepted. It sits on the master side of any AXI-Stream DUT, in simulation benches and in on-FPGA loopback tests.

## Interface
- DATA_W, 32: tdata width in bits; multiple of 8, from 8 to 512.
- ID_W, 4: tid width.
- DEST_W, 4: tdest width.
- LEN_W, 16: width of the packet byte-length field.
- CNT_W, 16: width of the packet-count and gap fields.
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- cfg_bytes  in  LEN_W  bytes per packet; 0 is treated as 1.
- cfg_pkts  in  CNT_W  number of packets; 0 means none.
- cfg_gap  in  CNT_W  idle cycles between packets.
- cfg_mode  in  2  data pattern: 0 = INCR, 1 = LFSR, 2 = CONST, 3 is reserved and behaves as CONST.
- cfg_seed  in  32  start value for the pattern.
- cfg_dest  in  DEST_W  tdest for every beat.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last packet completes.
- pkt_sent  out  CNT_W  count of completed packets in the current run.
- m_tvalid, m_tready(in), m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser(1 bit)  AXI-Stream master, with widths set by the parameters.

## Operation
- FSM states: IDLE → SEND ⇄ GAP → DONE → IDLE.
- IDLE:
  - start=1 latches all cfg_* inputs.
  - If cfg_pkts==0, go to DONE. Otherwise go to SEND.
- SEND:
  - m_tvalid=1 on every beat. A beat retires on m_tvalid && m_tready.
  - Beats per packet = ceil(bytes / (DATA_W/8)).
  - m_tlast is high on the final beat of each packet.
  - m_tkeep = m_tstrb = all ones, except on the last beat: low (bytes mod DATA_W/8) bits set, or all ones if the remainder is 0.
  - m_tuser = 1 on the first beat of each packet (SOF).
  - m_tid = packet index mod 2^ID_W. m_tdest = latched cfg_dest.
- On the last-beat handshake:
  - pkt_sent increments.
  - If it was the final packet, go to DONE.
  - Else if gap==0, stay in SEND and start the next packet on the next cycle (back-to-back).
  - Else go to GAP.
- GAP: m_tvalid=0 for exactly cfg_gap cycles, then SEND.
- DONE: done=1 for one cycle, busy=0, then IDLE. pkt_sent holds its value until the next accepted start.
- Pattern (32-bit value P, replicated across DATA_W and truncated in the top word if DATA_W is not a multiple of 32):
  - INCR: P = seed + global beat index, modulo 2^32.
  - LFSR: Galois, polynomial x^32+x^22+x^2+x+1. Loaded with seed, or 1 if seed==0. Advances once per retired beat.
  - CONST: P = seed.
- start outside IDLE is ignored. cfg_* changes after start have no effect.

## Timing
- Reset values: m_tvalid=0, m_tlast=0, m_tuser=0, all data and sideband buses 0, busy=0, done=0, pkt_sent=0, state IDLE, LFSR=1.
- Latency: start at cycle N produces m_tvalid=1 and busy=1 at cycle N+1.
- Outputs are registered. While m_tvalid && !m_tready, every m_* output holds its value indefinitely.
- m_tvalid is asserted regardless of m_tready, and never drops mid-packet.
- Throughput: one beat per cycle when m_tready=1, including across packet boundaries when gap==0.
- Last handshake at cycle M → done=1 at M+1 → IDLE at M+2. start is accepted again from M+2.
- areset mid-packet: all outputs are at their reset values on the next edge. The packet is abandoned, and no tlast or done is emitted.

## Structure
- Package axis_bfm_pkg:
  - enum gen_state_t {IDLE, SEND, GAP, DONE}
  - enum gen_mode_t {INCR, LFSR, CONST}
  - LFSR_POLY constant
  - function keep_mask(bytes, DATA_W)
- Sub-module axis_lfsr32: load, advance and value ports. It is instantiated once.
- The top level holds the FSM, the beat/packet/gap counters and the output registers.

## Test plan
- DATA_W=32, bytes=10, pkts=2, gap=0, INCR seed=0x100, tready=1 → 6 beats with tdata 0x100..0x105; tlast on beats 3 and 6; tkeep 0x3 on the last beats; tuser on beats 1 and 4; tid 0,1; done one cycle after beat 6.
- Same config with tready toggling on a random 50% schedule → every stalled beat is held stable, the sequence is identical to the first test, and tvalid never drops within a packet.
- bytes=4, pkts=3, gap=2, CONST seed=0xDEADBEEF → single-beat packets separated by exactly 2 tvalid-low cycles; pkt_sent ends at 3.
- LFSR with seed=0 → first beat 0x00000001, then reference-model LFSR values; DATA_W=64 replicates each value in both halves.
- cfg_pkts=0 → no tvalid, done at N+2, busy remains 0. start asserted while busy → ignored.
- areset asserted on beat 2 of a 5-beat packet → tvalid=0 and pkt_sent=0 on the next edge. A subsequent start produces a clean, full packet.
